// File: rtl/function_unit.sv
// rtl/function_unit.sv - 32-bit ALU with registered result and Z/C/N/V flags
module function_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       FS,
    output logic [WIDTH-1:0] S,
    output logic [3:0]       ZCNVFlags
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] FS_ADD  = 4'b0000;
    localparam logic [3:0] FS_SUB  = 4'b0001;
    localparam logic [3:0] FS_SLL  = 4'b0010;
    localparam logic [3:0] FS_SLT  = 4'b0100;
    localparam logic [3:0] FS_SLTU = 4'b0110;
    localparam logic [3:0] FS_XOR  = 4'b1000;
    localparam logic [3:0] FS_SRL  = 4'b1010;
    localparam logic [3:0] FS_SRA  = 4'b1011;
    localparam logic [3:0] FS_OR   = 4'b1100;
    localparam logic [3:0] FS_AND  = 4'b1110;

    logic [WIDTH-1:0] s_d, s_q;
    logic [3:0]       flags_d, flags_q;

    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   shamt;
    logic             c_flag;
    logic             v_flag;

    // Shared adder: SUB reuses it as A + ~B + 1 so C reads as "no borrow".
    always_comb begin
        add_b   = (FS == FS_SUB) ? ~B : B;
        add_cin = (FS == FS_SUB);
        sum     = {1'b0, A} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    end

    always_comb begin
        s_d    = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        shamt  = B[SHW-1:0];
        case (FS)
            FS_ADD, FS_SUB: begin
                s_d    = sum[WIDTH-1:0];
                c_flag = sum[WIDTH];
                v_flag = (A[WIDTH-1] == add_b[WIDTH-1]) &&
                         (sum[WIDTH-1] != A[WIDTH-1]);
            end
            FS_SLL:  s_d = A << shamt;
            FS_SLT:  s_d = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            FS_SLTU: s_d = {{(WIDTH-1){1'b0}}, (A < B)};
            FS_XOR:  s_d = A ^ B;
            FS_SRL:  s_d = A >> shamt;
            FS_SRA:  s_d = $unsigned($signed(A) >>> shamt);
            FS_OR:   s_d = A | B;
            FS_AND:  s_d = A & B;
            default: s_d = '0;
        endcase
        flags_d = {(s_d == '0), c_flag, s_d[WIDTH-1], v_flag};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            flags_q <= 4'b0000;
        end else begin
            s_q     <= s_d;
            flags_q <= flags_d;
        end
    end

    assign S         = s_q;
    assign ZCNVFlags = flags_q;

endmodule

// File: tb/tb_function_unit.sv
// tb/tb_function_unit.sv - directed self-checking bench for function_unit
module tb_function_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  FS;
    logic [31:0] S;
    logic [3:0]  ZCNVFlags;

    int tests_run;
    int tests_failed;

    localparam logic [3:0] ADD  = 4'b0000;
    localparam logic [3:0] SUB  = 4'b0001;
    localparam logic [3:0] SLL  = 4'b0010;
    localparam logic [3:0] SLT  = 4'b0100;
    localparam logic [3:0] SLTU = 4'b0110;
    localparam logic [3:0] XORO = 4'b1000;
    localparam logic [3:0] SRL  = 4'b1010;
    localparam logic [3:0] SRA  = 4'b1011;
    localparam logic [3:0] ORO  = 4'b1100;
    localparam logic [3:0] ANDO = 4'b1110;

    function_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .FS        (FS),
        .S         (S),
        .ZCNVFlags (ZCNVFlags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got S=%h flags=%b, expected S=%h flags=%b",
                     tag, got[35:4], got[3:0], exp[35:4], exp[3:0]);
        end
    endtask

    // Caller sits just after a rising edge; result is sampled 1 ns after the next edge.
    task automatic op(input string tag, input logic [3:0] fs, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] es, input logic [3:0] ef);
        FS = fs;
        A  = a;
        B  = b;
        @(posedge clk);
        #1;
        check(tag, {S, ZCNVFlags}, {es, ef});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        A  = 32'd7;
        B  = 32'd1;
        FS = ADD;
        #2;
        check("reset_init", {S, ZCNVFlags}, {32'h0, 4'b0000});
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_capture", {S, ZCNVFlags}, {32'h8, 4'b0000});

        op("7_add",  ADD,  32'd7, 32'd1, 32'h8, 4'b0000);
        op("7_sub",  SUB,  32'd7, 32'd1, 32'h6, 4'b0100);
        op("7_sll",  SLL,  32'd7, 32'd1, 32'hE, 4'b0000);
        op("7_slt",  SLT,  32'd7, 32'd1, 32'h0, 4'b1000);
        op("7_sltu", SLTU, 32'd7, 32'd1, 32'h0, 4'b1000);
        op("7_xor",  XORO, 32'd7, 32'd1, 32'h6, 4'b0000);
        op("7_srl",  SRL,  32'd7, 32'd1, 32'h3, 4'b0000);
        op("7_sra",  SRA,  32'd7, 32'd1, 32'h3, 4'b0000);
        op("7_or",   ORO,  32'd7, 32'd1, 32'h7, 4'b0000);
        op("7_and",  ANDO, 32'd7, 32'd1, 32'h1, 4'b0000);

        op("mx_add", ADD,  32'h7FFFFFFF, 32'd1, 32'h80000000, 4'b0011);
        op("mx_sub", SUB,  32'h7FFFFFFF, 32'd1, 32'h7FFFFFFE, 4'b0100);
        op("mx_sll", SLL,  32'h7FFFFFFF, 32'd1, 32'hFFFFFFFE, 4'b0010);
        op("mx_xor", XORO, 32'h7FFFFFFF, 32'd1, 32'h7FFFFFFE, 4'b0000);
        op("mx_srl", SRL,  32'h7FFFFFFF, 32'd1, 32'h3FFFFFFF, 4'b0000);
        op("mx_sra", SRA,  32'h7FFFFFFF, 32'd1, 32'h3FFFFFFF, 4'b0000);
        op("mx_or",  ORO,  32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 4'b0000);
        op("mx_and", ANDO, 32'h7FFFFFFF, 32'd1, 32'h00000001, 4'b0000);

        op("ff_add",  ADD,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0110);
        op("ff_sub",  SUB,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b1100);
        op("ff_sll",  SLL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 4'b0010);
        op("ff_slt",  SLT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b1000);
        op("ff_sltu", SLTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b1000);
        op("ff_xor",  XORO, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b1000);
        op("ff_srl",  SRL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000);
        op("ff_sra",  SRA,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0010);
        op("ff_or",   ORO,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0010);
        op("ff_and",  ANDO, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0010);

        op("sgn_slt",  SLT,  32'h80000000, 32'd1, 32'h1, 4'b0000);
        op("sgn_sltu", SLTU, 32'h80000000, 32'd1, 32'h0, 4'b1000);
        op("sgn_sub",  SUB,  32'h80000000, 32'd1, 32'h7FFFFFFF, 4'b0101);
        op("borrow",   SUB,  32'd1, 32'd2, 32'hFFFFFFFF, 4'b0010);

        op("sh0_sll",  SLL, 32'h12345678, 32'h00000020, 32'h12345678, 4'b0000);
        op("sh0_sra",  SRA, 32'h80000000, 32'h00000000, 32'h80000000, 4'b0010);
        op("sra_neg",  SRA, 32'h80000000, 32'h00000004, 32'hF8000000, 4'b0010);
        op("hi_ign",   SLL, 32'h00000001, 32'hFFFFFFE1, 32'h00000002, 4'b0000);

        op("undef_3",  4'b0011, 32'd7, 32'd1, 32'h0, 4'b1000);
        op("undef_f",  4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 4'b1000);

        op("pre_rst", ADD, 32'h100, 32'h23, 32'h123, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", {S, ZCNVFlags}, {32'h0, 4'b0000});
        FS = ADD;
        A  = 32'd7;
        B  = 32'd1;
        @(posedge clk);
        #1;
        check("rst_hold", {S, ZCNVFlags}, {32'h0, 4'b0000});
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release", {S, ZCNVFlags}, {32'h8, 4'b0000});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
